// File: rtl/cmd_frame_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_frame_pkg: states and command/response codes for cmd_frame_engine. rev 1.0
// ---------------------------------------------------------------------------
package cmd_frame_pkg;

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_ADDR  = 3'd1,
        S_VALUE = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ         = 8'h00;
    localparam logic [7:0] CMD_WRITE        = 8'hAA;
    localparam logic [7:0] RESP_ACK         = 8'h06;
    localparam logic [7:0] RESP_NAK_CMD     = 8'h15;
    localparam logic [7:0] RESP_NAK_TIMEOUT = 8'h18;

endpackage
`default_nettype wire

// File: rtl/cmd_resp_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_resp_serializer: parallel-loaded response words out over valid/ready. rev 1.0
// ---------------------------------------------------------------------------
module cmd_resp_serializer #(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_WORDS  = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic [WORD_WIDTH*MAX_WORDS-1:0]      load_words,
    input  logic [$clog2(MAX_WORDS+1)-1:0]       load_count,
    output logic [WORD_WIDTH-1:0]                tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic                                 done
);
    localparam int BW = WORD_WIDTH * MAX_WORDS;
    localparam int CW = $clog2(MAX_WORDS + 1);

    logic [BW-1:0] r_buf;
    logic [CW-1:0] r_left;

    // First word goes straight to tx_data; r_buf holds the rest, MSW-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf    <= '0;
            r_left   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                tx_data  <= load_words[BW-1 -: WORD_WIDTH];
                r_buf    <= BW'({load_words, {WORD_WIDTH{1'b0}}});
                r_left   <= load_count;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                if (r_left == CW'(1)) begin
                    tx_valid <= 1'b0;
                    r_left   <= '0;
                    done     <= 1'b1;
                end else begin
                    tx_data <= r_buf[BW-1 -: WORD_WIDTH];
                    r_buf   <= BW'({r_buf, {WORD_WIDTH{1'b0}}});
                    r_left  <= r_left - CW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_frame_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_frame_engine: framed command words -> register write/read strobes + status. rev 1.0
// ---------------------------------------------------------------------------
module cmd_frame_engine
    import cmd_frame_pkg::*;
#(
    parameter int WORD_WIDTH     = 8,
    parameter int ADDR_WORDS     = 1,
    parameter int VALUE_WORDS    = 4,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic [WORD_WIDTH-1:0]             i_data,
    input  logic                              i_dv,
    output logic [ADDR_WORDS*WORD_WIDTH-1:0]  o_addr,
    output logic [VALUE_WORDS*WORD_WIDTH-1:0] o_w_data,
    output logic                              o_w_en,
    output logic                              o_r_en,
    input  logic [VALUE_WORDS*WORD_WIDTH-1:0] i_r_data,
    output logic [WORD_WIDTH-1:0]             o_tx_data,
    output logic                              o_tx_valid,
    input  logic                              i_tx_ready,
    output logic                              o_busy,
    output logic                              o_drop
);
    localparam int AW         = ADDR_WORDS * WORD_WIDTH;
    localparam int DW         = VALUE_WORDS * WORD_WIDTH;
    localparam int RESP_WORDS = VALUE_WORDS + 1;
    localparam int RW         = RESP_WORDS * WORD_WIDTH;
    localparam int RCW        = $clog2(RESP_WORDS + 1);
    localparam int CNT_W      = 16;
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    logic               r_is_write;
    logic [CNT_W-1:0]   r_cnt;
    logic [TO_W-1:0]    r_idle;

    logic               w_is_cmd_w, w_is_cmd_r, w_bad_cmd, w_timeout;
    logic               w_rd_capture, w_load, w_discard, w_done;
    logic [RW-1:0]      w_load_words;
    logic [RCW-1:0]     w_load_count;

    // Every path into S_RESP is a serializer load, so w_load alone steers the FSM there.
    always_comb begin
        w_is_cmd_w   = (i_data == WORD_WIDTH'(CMD_WRITE));
        w_is_cmd_r   = (i_data == WORD_WIDTH'(CMD_READ));
        w_bad_cmd    = (r_state == S_CMD) && i_dv && !w_is_cmd_w && !w_is_cmd_r;
        w_timeout    = ((r_state == S_ADDR) || (r_state == S_VALUE)) && !i_dv
                       && (r_idle == TO_W'(TIMEOUT_CYCLES - 1));
        w_rd_capture = (r_state == S_READ) && (r_cnt == CNT_W'(READ_LATENCY));
        w_load       = w_bad_cmd || w_timeout || w_rd_capture || (r_state == S_WRITE);
        w_discard    = i_dv && ((r_state == S_WRITE) || (r_state == S_READ)
                                || (r_state == S_RESP));
        w_load_words = {WORD_WIDTH'(RESP_ACK), {DW{1'b0}}};
        w_load_count = RCW'(1);
        if (w_bad_cmd) begin
            w_load_words = {WORD_WIDTH'(RESP_NAK_CMD), {DW{1'b0}}};
        end else if (w_timeout) begin
            w_load_words = {WORD_WIDTH'(RESP_NAK_TIMEOUT), {DW{1'b0}}};
        end else if (w_rd_capture) begin
            w_load_words = {WORD_WIDTH'(RESP_ACK), i_r_data};
            w_load_count = RCW'(RESP_WORDS);
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_CMD;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_idle     <= '0;
            o_addr     <= '0;
            o_w_data   <= '0;
            o_w_en     <= 1'b0;
            o_r_en     <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_w_en <= 1'b0;
            o_r_en <= 1'b0;
            o_drop <= w_discard;
            case (r_state)
                S_CMD: begin
                    if (i_dv) begin
                        r_is_write <= w_is_cmd_w;
                        r_cnt      <= '0;
                        r_idle     <= '0;
                        if (!w_bad_cmd) r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (i_dv) begin
                        o_addr <= AW'({o_addr, i_data});
                        r_idle <= '0;
                        if (r_cnt == CNT_W'(ADDR_WORDS - 1)) begin
                            r_cnt <= '0;
                            if (r_is_write) begin
                                r_state <= S_VALUE;
                            end else begin
                                r_state <= S_READ;
                                o_r_en  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (!w_timeout) begin
                        r_idle <= r_idle + TO_W'(1);
                    end
                end
                S_VALUE: begin
                    if (i_dv) begin
                        o_w_data <= DW'({o_w_data, i_data});
                        r_idle   <= '0;
                        if (r_cnt == CNT_W'(VALUE_WORDS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_WRITE;
                            o_w_en  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (!w_timeout) begin
                        r_idle <= r_idle + TO_W'(1);
                    end
                end
                S_WRITE: ;
                S_READ: begin
                    if (!w_rd_capture) r_cnt <= r_cnt + CNT_W'(1);
                end
                S_RESP: begin
                    if (w_done) r_state <= S_CMD;
                end
                default: r_state <= S_CMD;
            endcase
            if (w_load) r_state <= S_RESP;
        end
    end

    assign o_busy = (r_state != S_CMD);

    cmd_resp_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .MAX_WORDS  (RESP_WORDS)
    ) u_resp (
        .clk        (clk),
        .rst        (i_reset),
        .load       (w_load),
        .load_words (w_load_words),
        .load_count (w_load_count),
        .tx_data    (o_tx_data),
        .tx_valid   (o_tx_valid),
        .tx_ready   (i_tx_ready),
        .done       (w_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmd_frame_engine: scoreboard bench for cmd_frame_engine (default parameters). rev 1.0
// ---------------------------------------------------------------------------
module tb_cmd_frame_engine;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_data = '0;
    logic        i_dv = 1'b0;
    logic [7:0]  o_addr;
    logic [31:0] o_w_data;
    logic        o_w_en, o_r_en;
    logic [31:0] i_r_data = '0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy, o_drop;

    cmd_frame_engine dut (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
        .o_addr(o_addr), .o_w_data(o_w_data), .o_w_en(o_w_en), .o_r_en(o_r_en),
        .i_r_data(i_r_data), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int w_cnt = 0;
    int r_cnt = 0;
    int drop_cnt = 0;

    logic [7:0]  tx_q[$];
    logic [39:0] w_q[$];
    logic [7:0]  r_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] rd_value = '0;
    logic        r_seen = 1'b0;
    logic        stall_prev = 1'b0;
    logic [7:0]  held = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Register-file model: data valid one cycle after o_r_en, garbage otherwise.
    always @(negedge clk) begin
        i_r_data = r_seen ? rd_value : 32'hBAAD_F00D;
        r_seen   = o_r_en;
    end

    always @(negedge clk) begin
        if (!i_reset) begin
            if (stall_prev) begin
                chk("tx_hold_valid", o_tx_valid, 1);
                chk("tx_hold_data", o_tx_data, held);
            end
            stall_prev = o_tx_valid && !i_tx_ready;
            held       = o_tx_data;
            if (o_tx_valid && i_tx_ready) begin
                if (tx_q.size() == 0) chk("tx_unexpected", o_tx_valid, 0);
                else chk("tx_word", o_tx_data, tx_q.pop_front());
            end
            if (o_w_en) begin
                w_cnt++;
                if (w_q.size() == 0) chk("w_unexpected", o_w_en, 0);
                else begin
                    logic [39:0] e;
                    e = w_q.pop_front();
                    chk("w_addr", o_addr, e[39:32]);
                    chk("w_data", o_w_data, e[31:0]);
                end
            end
            if (o_r_en) begin
                r_cnt++;
                if (r_q.size() == 0) chk("r_unexpected", o_r_en, 0);
                else chk("r_addr", o_addr, r_q.pop_front());
            end
            if (o_drop) drop_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Back-to-back words from frame_q; returns at +1 after the edge that took the last word.
    task automatic send_frame();
        foreach (frame_q[k]) begin
            @(posedge clk); #1;
            i_data = frame_q[k];
            i_dv   = 1'b1;
        end
        @(posedge clk); #1;
        i_dv = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0 && !o_busy) ok = 1'b1;
        end
        chk("idle_wait", ok, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"}, o_addr, 0);
        chk({tag, "_wdata"}, o_w_data, 0);
        chk({tag, "_wen"}, o_w_en, 0);
        chk({tag, "_ren"}, o_r_en, 0);
        chk({tag, "_txv"}, o_tx_valid, 0);
        chk({tag, "_txd"}, o_tx_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_drop"}, o_drop, 0);
    endtask

    initial begin
        int n;
        #1;
        check_reset_values("rst");
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;

        // Write frame
        w_q.push_back({8'h10, 32'hDEADBEEF});
        tx_q.push_back(8'h06);
        frame_q = '{8'hAA, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame();
        @(negedge clk);
        chk("w_latency", o_w_en, 1);
        wait_idle(50);

        // Read frame
        rd_value = 32'h01234567;
        r_q.push_back(8'h22);
        tx_q.push_back(8'h06); tx_q.push_back(8'h01); tx_q.push_back(8'h23);
        tx_q.push_back(8'h45); tx_q.push_back(8'h67);
        frame_q = '{8'h00, 8'h22};
        send_frame();
        @(negedge clk);
        chk("r_latency", o_r_en, 1);
        wait_idle(50);

        // Bad command, then a normal write
        tx_q.push_back(8'h15);
        frame_q = '{8'h5A};
        send_frame();
        wait_idle(50);
        chk("nak_busy", o_busy, 0);
        w_q.push_back({8'h01, 32'h00000007});
        tx_q.push_back(8'h06);
        frame_q = '{8'hAA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07};
        send_frame();
        wait_idle(50);

        // Timeout inside the value field
        tx_q.push_back(8'h18);
        frame_q = '{8'hAA, 8'h10, 8'hDE};
        send_frame();
        n = 0;
        for (int i = 1; i <= TO + 20 && n == 0; i++) begin
            @(negedge clk);
            if (o_tx_valid) n = i;
        end
        chk("to_window", (n >= TO && n <= TO + 2), 1);
        wait_idle(50);
        chk("to_busy", o_busy, 0);

        // Read under backpressure with a stray word during the response
        i_tx_ready = 1'b0;
        rd_value = 32'hCAFEF00D;
        r_q.push_back(8'h33);
        tx_q.push_back(8'h06); tx_q.push_back(8'hCA); tx_q.push_back(8'hFE);
        tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
        frame_q = '{8'h00, 8'h33};
        send_frame();
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            @(negedge clk);
            if (o_tx_valid) n = 1;
        end
        chk("bp_valid", n, 1);
        frame_q = '{8'h77};
        send_frame();
        repeat (20) @(posedge clk);
        #1 i_tx_ready = 1'b1;
        wait_idle(50);
        chk("drop_count", drop_cnt, 1);

        // Asynchronous reset mid-value, then a full write
        frame_q = '{8'hAA, 8'h10, 8'hDE};
        send_frame();
        @(negedge clk);
        chk("mid_busy", o_busy, 1);
        @(posedge clk); #3;
        i_reset = 1'b1;
        #1;
        check_reset_values("arst");
        @(posedge clk); #1;
        i_reset = 1'b0;
        w_q.push_back({8'h44, 32'h11223344});
        tx_q.push_back(8'h06);
        frame_q = '{8'hAA, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame();
        wait_idle(50);

        chk("w_count", w_cnt, 3);
        chk("r_count", r_cnt, 2);
        chk("tx_q_left", tx_q.size(), 0);
        chk("w_q_left", w_q.size(), 0);
        chk("r_q_left", r_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=expired expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cmd_frame_engine.md
Name: cmd_frame_engine

Overview:
Parametrised successor to the byte-stream command controller. Parses framed command words from a serial receiver (e.g. UART RX) into register-bus write and read strobes. Returns an ACK/NAK status word, plus read data, over a valid/ready transmit stream. Adds multi-word addresses, per-frame timeout, read-data return, dropped-word reporting and an asynchronous reset. Sits between the UART RX/TX pair and the register file.

Parameters:
WORD_WIDTH, 8, bits per stream word
ADDR_WORDS, 1, address words per frame; address width AW = ADDR_WORDS*WORD_WIDTH
VALUE_WORDS, 4, data words per write/read; data width DW = VALUE_WORDS*WORD_WIDTH
READ_LATENCY, 1, cycles from o_r_en to i_r_data valid (>=1)
TIMEOUT_CYCLES, 1000, idle cycles between words inside a frame before the frame aborts (>=2)

Ports:
clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_data  in  WORD_WIDTH  received word
i_dv  in  1  single-cycle strobe: i_data valid this cycle
o_addr  out  AW  register address for both read and write
o_w_data  out  DW  write data
o_w_en  out  1  write strobe, one cycle
o_r_en  out  1  read strobe, one cycle
i_r_data  in  DW  read data, sampled READ_LATENCY cycles after o_r_en
o_tx_data  out  WORD_WIDTH  response word
o_tx_valid  out  1  response word valid
i_tx_ready  in  1  response sink ready; transfer occurs when valid && ready
o_busy  out  1  high in any state other than S_CMD
o_drop  out  1  one-cycle pulse when an i_dv word is discarded

Behaviour:
- Reset is asynchronous and applies to every flop, with these values:
  - state=S_CMD; o_addr=0; o_w_data=0; all strobes=0; o_tx_valid=0; o_tx_data=0; all counters=0.
- Frame format: C, A(ADDR_WORDS), then V(VALUE_WORDS) for writes only. All multi-word fields are MSW first.
- Command codes: CMD_READ=0x00, CMD_WRITE=0xAA. Response codes: ACK=0x06, NAK_CMD=0x15, NAK_TIMEOUT=0x18. Codes wider than WORD_WIDTH are truncated.
- Every word is consumed only on the cycle i_dv=1. There is no edge detection.
- State machine:
  - S_CMD: on i_dv, latch the command. READ or WRITE -> S_ADDR. Any other code -> S_RESP with NAK_CMD queued.
  - S_ADDR: shift each word into o_addr, count to ADDR_WORDS. On the last word: WRITE -> S_VALUE; READ -> S_READ.
  - S_VALUE: shift each word into o_w_data, count to VALUE_WORDS. On the last word -> S_WRITE.
  - S_WRITE: o_w_en=1 for exactly one cycle; queue ACK; -> S_RESP.
  - S_READ: o_r_en=1 for one cycle, then wait READ_LATENCY cycles. Capture i_r_data into the response buffer, queue ACK followed by VALUE_WORDS data words; -> S_RESP.
  - S_RESP: present queued words in order on o_tx_*. Hold o_tx_data stable while valid && !ready. After the final handshake -> S_CMD.
- o_addr and o_w_data are stable throughout o_w_en/o_r_en. They hold their values after the frame until overwritten by the next frame.
- Timeout: in S_ADDR/S_VALUE, count cycles since the last i_dv. Reaching TIMEOUT_CYCLES -> S_RESP with NAK_TIMEOUT; no strobe is issued. A partially shifted o_addr/o_w_data is undefined after a timeout.
- i_dv in S_WRITE, S_READ or S_RESP: the word is discarded, o_drop pulses the next cycle, and the state is unaffected.
- Response length: 1 word for a write or NAK; 1+VALUE_WORDS words for a read.
- Minimum latency, last frame word i_dv to o_w_en: 1 cycle. To o_r_en: 1 cycle.
- i_tx_ready low indefinitely: stay in S_RESP, with no timeout in this state.
- Reset asserted mid-frame or mid-response: immediate return to reset values. A partial response is never resumed.

Decomposition:
- cmd_frame_pkg holds:
  - state enum: S_CMD, S_ADDR, S_VALUE, S_WRITE, S_READ, S_RESP
  - command and response code localparams
- One sub-module, cmd_resp_serializer: loads up to 1+VALUE_WORDS words in parallel and drives o_tx_data/o_tx_valid with a valid/ready handshake. It pulses done after the last transfer.

Test Plan:
- Write: default params, words AA 10 DE AD BE EF, i_tx_ready=1 -> one o_w_en pulse with o_addr=0x10, o_w_data=0xDEADBEEF; then tx 0x06 once.
- Read: words 00 22, model returns 0x01234567 READ_LATENCY=1 after o_r_en -> one o_r_en pulse, o_addr=0x22; then tx 06 01 23 45 67 in order; no o_w_en.
- Bad command 0x5A -> tx 0x15, no strobes, back to S_CMD; the following AA 01 00 00 00 07 frame writes 0x00000007 to 0x01.
- Timeout: AA 10 DE, then silence for TIMEOUT_CYCLES -> tx 0x18, no o_w_en, o_busy falls after the handshake.
- Backpressure/drop: read with i_tx_ready=0 for 20 cycles, extra i_dv during S_RESP -> o_tx_data stable while stalled, o_drop pulses once, all 5 words delivered.
- Async reset: assert i_reset between edges mid-S_VALUE -> outputs at reset values before the next clk edge; a subsequent full write frame succeeds.
